// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and saturating helpers for the branch predictor
package bp_pkg;

  localparam int DEF_INDEX_BITS = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag is held at its widest possible size so the struct fits any INDEX_BITS
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;

  function automatic ctr_t sat_inc(ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t sat_dec(ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/btb_ram.sv
// btb_ram: direct-mapped BTB storage, two async read ports and one sync write port
module btb_ram
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx_a,
  output btb_entry_t            rd_a,
  input  logic [INDEX_BITS-1:0] rd_idx_b,
  output btb_entry_t            rd_b,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_data
);

  btb_entry_t mem [2**INDEX_BITS];

  // Reset clears every entry (valid and counter to zero); otherwise one write per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**INDEX_BITS; i++) mem[i] <= '0;
    else if (wr_en)
      mem[wr_idx] <= wr_data;

  assign rd_a = mem[rd_idx_a];
  assign rd_b = mem[rd_idx_b];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage BTB lookup, MEM-stage training, mispredict flush and perf counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int PERF_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_pc_if,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_target,
  input  logic              i_update_valid,
  input  logic [31:0]       i_pc_mem,
  input  logic              i_is_jump_mem,
  input  logic              i_actual_taken,
  input  logic [31:0]       i_actual_target,
  input  logic              i_pred_taken_mem,
  input  logic [31:0]       i_pred_target_mem,
  output logic              o_mispredict,
  output logic [31:0]       o_redirect_pc,
  output logic [PERF_W-1:0] o_branch_cnt,
  output logic [PERF_W-1:0] o_mispred_cnt
);

  function automatic logic [29:0] tag_of(logic [31:0] pc);
    return 30'(pc[31:INDEX_BITS+2]);
  endfunction

  btb_entry_t e_if, e_mem, wr_data;
  logic       wr_en, hit_if, hit_mem;

  btb_ram #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .rd_idx_a (i_pc_if[INDEX_BITS+1:2]),
    .rd_a     (e_if),
    .rd_idx_b (i_pc_mem[INDEX_BITS+1:2]),
    .rd_b     (e_mem),
    .wr_en    (wr_en),
    .wr_idx   (i_pc_mem[INDEX_BITS+1:2]),
    .wr_data  (wr_data)
  );

  assign hit_if        = e_if.valid && e_if.tag == tag_of(i_pc_if);
  assign hit_mem       = e_mem.valid && e_mem.tag == tag_of(i_pc_mem);
  assign o_pred_taken  = hit_if && e_if.ctr[1];
  assign o_pred_target = hit_if ? e_if.target : i_pc_if + 32'd4;
  assign o_mispredict  = i_update_valid && ((i_pred_taken_mem != i_actual_taken) ||
                         (i_actual_taken && i_pred_target_mem != i_actual_target));
  assign o_redirect_pc = i_actual_taken ? i_actual_target : i_pc_mem + 32'd4;

  // Training: hits adjust the counter/target, taken misses allocate, not-taken misses leave the BTB alone
  always_comb begin
    wr_en   = 1'b0;
    wr_data = e_mem;
    if (i_update_valid && hit_mem) begin
      wr_en          = 1'b1;
      wr_data.ctr    = i_is_jump_mem ? ST : i_actual_taken ? sat_inc(e_mem.ctr) : sat_dec(e_mem.ctr);
      wr_data.target = i_actual_taken ? i_actual_target : e_mem.target;
    end else if (i_update_valid && i_actual_taken) begin
      wr_en   = 1'b1;
      wr_data = '{valid: 1'b1, tag: tag_of(i_pc_mem), target: i_actual_target,
                  ctr: i_is_jump_mem ? ST : WT};
    end
  end

  // Saturating performance counters; they stop at all-ones instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_branch_cnt  <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (i_update_valid && !(&o_branch_cnt)) o_branch_cnt <= o_branch_cnt + 1'b1;
      if (o_mispredict && !(&o_mispred_cnt)) o_mispred_cnt <= o_mispred_cnt + 1'b1;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with a queued scoreboard drained by a negedge monitor
module tb_branch_predictor;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc_if, pc_mem, actual_target, pred_target_mem, pred_target, redirect_pc;
  logic          update_valid, is_jump_mem, actual_taken, pred_taken_mem;
  logic          pred_taken, mispredict;
  logic [PW-1:0] branch_cnt, mispred_cnt;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(4), .PERF_W(PW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pc_if           (pc_if),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_update_valid    (update_valid),
    .i_pc_mem          (pc_mem),
    .i_is_jump_mem     (is_jump_mem),
    .i_actual_taken    (actual_taken),
    .i_actual_target   (actual_target),
    .i_pred_taken_mem  (pred_taken_mem),
    .i_pred_target_mem (pred_target_mem),
    .o_mispredict      (mispredict),
    .o_redirect_pc     (redirect_pc),
    .o_branch_cnt      (branch_cnt),
    .o_mispred_cnt     (mispred_cnt)
  );

  // Monitor: on every falling edge compare whatever expectations are pending
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] got;
      e = q.pop_front();
      case (e.kind)
        0:       got = {31'b0, pred_taken};
        1:       got = pred_target;
        2:       got = {31'b0, mispredict};
        3:       got = redirect_pc;
        4:       got = 32'(branch_cnt);
        default: got = 32'(mispred_cnt);
      endcase
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", e.name, $time, got, e.val);
      end
    end
  end

  task automatic push(input string n, input int k, input logic [31:0] v);
    q.push_back('{name: n, kind: k, val: v});
  endtask

  task automatic exp_pred(input logic t, input logic [31:0] tg);
    push("pred_taken", 0, {31'b0, t});
    push("pred_target", 1, tg);
  endtask

  task automatic exp_mis(input logic m, input logic [31:0] r);
    push("mispredict", 2, {31'b0, m});
    push("redirect_pc", 3, r);
  endtask

  task automatic exp_cnt(input int b, input int m);
    push("branch_cnt", 4, 32'(b));
    push("mispred_cnt", 5, 32'(m));
  endtask

  task automatic step(input logic [31:0] pif, input logic uv, input logic [31:0] pm,
                      input logic j, input logic at, input logic [31:0] tg,
                      input logic pt, input logic [31:0] ptg);
    @(posedge clk);
    #1;
    pc_if           = pif;
    update_valid    = uv;
    pc_mem          = pm;
    is_jump_mem     = j;
    actual_taken    = at;
    actual_target   = tg;
    pred_taken_mem  = pt;
    pred_target_mem = ptg;
  endtask

  task automatic look(input logic [31:0] pif);
    step(pif, 1'b0, pif, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_if = 32'h100; pc_mem = 32'h0; update_valid = 1'b0; is_jump_mem = 1'b0;
    actual_taken = 1'b0; actual_target = 32'h0; pred_taken_mem = 1'b0; pred_target_mem = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    look(32'h100);                   exp_pred(0, 32'h104); exp_mis(0, 32'h104); exp_cnt(0, 0);
    step(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104); exp_pred(0, 32'h104); exp_mis(1, 32'h80);
    look(32'h100);                   exp_pred(1, 32'h80); exp_cnt(1, 1);
    step(32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80);  exp_mis(1, 32'h104);
    look(32'h100);                   exp_pred(0, 32'h80); exp_cnt(2, 2);
    step(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104); exp_mis(0, 32'h104);
    step(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104); exp_mis(0, 32'h104); exp_cnt(3, 2);
    step(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104); exp_mis(1, 32'h80); exp_cnt(4, 2);
    look(32'h100);                   exp_pred(0, 32'h80); exp_cnt(5, 3);
    step(32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 32'h204); exp_pred(0, 32'h204); exp_mis(1, 32'h400);
    look(32'h200);                   exp_pred(1, 32'h400); exp_cnt(6, 4);
    step(32'h200, 1, 32'h200, 1, 1, 32'h500, 1, 32'h400); exp_pred(1, 32'h400); exp_mis(1, 32'h500);
    look(32'h200);                   exp_pred(1, 32'h500); exp_cnt(7, 5);
    step(32'h200, 1, 32'h200, 0, 0, 32'h500, 1, 32'h500); exp_mis(1, 32'h204);
    look(32'h200);                   exp_pred(1, 32'h500); exp_cnt(8, 6);
    step(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104); exp_pred(0, 32'h104); exp_mis(1, 32'h80);
    look(32'h100);                   exp_pred(1, 32'h80); exp_cnt(9, 7);
    step(32'h140, 1, 32'h140, 0, 1, 32'h300, 0, 32'h144); exp_pred(0, 32'h144); exp_mis(1, 32'h300);
    look(32'h100);                   exp_pred(0, 32'h104); exp_cnt(10, 8);
    look(32'h140);                   exp_pred(1, 32'h300);
    step(32'h104, 1, 32'h104, 0, 0, 32'h999, 0, 32'h108); exp_mis(0, 32'h108); exp_cnt(10, 8);
    look(32'h104);                   exp_pred(0, 32'h108); exp_cnt(11, 8);
    for (int i = 0; i < 9; i++) begin
      step(32'h104, 1, 32'h104, 0, 0, 32'h999, 1, 32'h999);
      exp_mis(1, 32'h108);
      exp_cnt((11 + i > 15) ? 15 : 11 + i, (8 + i > 15) ? 15 : 8 + i);
    end
    look(32'h140);                   exp_pred(1, 32'h300); exp_cnt(15, 15);
    look(32'h140);                   exp_cnt(15, 15);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_pred(0, 32'h144); exp_cnt(0, 0);
    look(32'h200);
    rst_n = 1'b1;
    exp_pred(0, 32'h204); exp_mis(0, 32'h204); exp_cnt(0, 0);
    look(32'h140);                   exp_pred(0, 32'h144); exp_cnt(0, 0);
    look(32'h100);                   exp_pred(0, 32'h104);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
